// File: rtl/mult_bcd_conv.sv
// mult_bcd_conv
// Snapshots the multiplier product S when mult_done is high. Converts it to
// BCD with an iterative shift-add-3 (double-dabble) sequencer. Presents the
// registered digits with a valid flag and a one-cycle done pulse.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   S          - binary product from the multiplier (BIN_W bits)
//   mult_done  - multiplier result-valid level
//   bcd_ones   - BCD ones digit (registered)
//   bcd_tens   - BCD tens digit (registered)
//   bcd_hund   - BCD hundreds digit (registered)
//   bcd_valid  - digits hold a completed conversion of the current product
//   busy       - conversion in progress
//   conv_done  - one-cycle pulse when the digits update
module mult_bcd_conv #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] S,
    input  logic             mult_done,
    output logic [3:0]       bcd_ones,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_hund,
    output logic             bcd_valid,
    output logic             busy,
    output logic             conv_done
);

    localparam int         WW       = 4*DIGITS + BIN_W;
    localparam int         PD       = (DIGITS > 3) ? DIGITS : 3;
    localparam logic [3:0] CNT_LAST = 4'(BIN_W - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    work_q, work_d, work_adj;
    logic [3:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0] last_q, last_d;
    logic [3:0]       ones_d, tens_d, hund_d;
    logic             valid_d, busy_d, done_d;
    logic [4*PD-1:0]  dig_ext;

    // Add-3 correction on every digit >= 5, ahead of the shift, so no
    // digit can reach 10 after doubling.
    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[BIN_W+4*i +: 4] >= 4'd5)
                work_adj[BIN_W+4*i +: 4] = work_q[BIN_W+4*i +: 4] + 4'd3;
        end
    end

    // Digit field widened to at least three digits so the fixed output
    // ports can always be sliced, whatever DIGITS is.
    always_comb begin
        dig_ext = '0;
        dig_ext[4*DIGITS-1:0] = work_q[WW-1:BIN_W];
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ones_d  = bcd_ones;
        tens_d  = bcd_tens;
        hund_d  = bcd_hund;
        valid_d = bcd_valid;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mult_done && (!bcd_valid || S != last_q)) begin
                    work_d  = {{(4*DIGITS){1'b0}}, S};
                    cnt_d   = '0;
                    last_d  = S;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end else if (!mult_done) begin
                    // Multiplier is showing 0: drop the stale result.
                    valid_d = 1'b0;
                    ones_d  = '0;
                    tens_d  = '0;
                    hund_d  = '0;
                    last_d  = '0;
                end
            end
            CONV, DONE: begin
                if (!mult_done) begin
                    // Product withdrawn mid-conversion: abort and clear.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    ones_d  = '0;
                    tens_d  = '0;
                    hund_d  = '0;
                    last_d  = '0;
                    cnt_d   = '0;
                    work_d  = '0;
                end else if (state_q == CONV) begin
                    work_d = work_adj << 1;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST)
                        state_d = DONE;
                end else begin
                    ones_d  = dig_ext[3:0];
                    tens_d  = dig_ext[7:4];
                    hund_d  = dig_ext[11:8];
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            last_q    <= '0;
            bcd_ones  <= '0;
            bcd_tens  <= '0;
            bcd_hund  <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
            conv_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            bcd_ones  <= ones_d;
            bcd_tens  <= tens_d;
            bcd_hund  <= hund_d;
            bcd_valid <= valid_d;
            busy      <= busy_d;
            conv_done <= done_d;
        end
    end

endmodule

// File: tb/tb_mult_bcd_conv.sv
// Testbench for mult_bcd_conv. A cycle-level reference model built from
// decimal arithmetic (value/100, /10, %10) is checked against the outputs
// every cycle. A vector table and hand sequences cover the corner cases.
module tb_mult_bcd_conv;

    localparam int BIN_W = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] S = '0;
    logic       mult_done = 1'b0;
    logic [3:0] bcd_ones, bcd_tens, bcd_hund;
    logic       bcd_valid, busy, conv_done;

    mult_bcd_conv #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .reset(reset), .S(S), .mult_done(mult_done),
        .bcd_ones(bcd_ones), .bcd_tens(bcd_tens), .bcd_hund(bcd_hund),
        .bcd_valid(bcd_valid), .busy(busy), .conv_done(conv_done)
    );

    always #5 clk = ~clk;

    logic [19:0] wq;
    assign wq = dut.work_q;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int       m_left;   // edges left until the result lands (0 = idle)
    int       m_snap;
    int       m_last;
    logic [3:0] m_h, m_t, m_o;
    logic     m_valid, m_busy, m_done;

    typedef struct {
        logic [7:0]  val;
        logic [11:0] digits;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_snap = 0; m_last = 0;
        m_h = 0; m_t = 0; m_o = 0;
        m_valid = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic model_edge();
        m_done = 0;
        if (m_left > 0) begin
            if (!mult_done) begin
                m_left = 0; m_busy = 0; m_valid = 0;
                m_h = 0; m_t = 0; m_o = 0; m_last = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_h = 4'(m_snap / 100);
                    m_t = 4'((m_snap / 10) % 10);
                    m_o = 4'(m_snap % 10);
                    m_valid = 1; m_done = 1; m_busy = 0;
                end
            end
        end else if (mult_done && (!m_valid || int'(S) != m_last)) begin
            m_snap = int'(S); m_last = int'(S);
            m_left = BIN_W + 1; m_busy = 1;
        end else if (!mult_done) begin
            m_valid = 0; m_h = 0; m_t = 0; m_o = 0; m_last = 0;
        end
    endtask

    task automatic check_outputs(input string name);
        check(name, {17'd0, bcd_hund, bcd_tens, bcd_ones, bcd_valid, busy, conv_done},
                    {17'd0, m_h, m_t, m_o, m_valid, m_busy, m_done});
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        #1;
        check_outputs("cycle_outputs");
        check("work_digits_le9",
              32'((wq[11:8] <= 4'd9) && (wq[15:12] <= 4'd9) && (wq[19:16] <= 4'd9)), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin step(); n++; end while (!conv_done && n < 40);
        check({name, "_done_seen"}, 32'(conv_done), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{8'd225, 12'h225};
        vecs[1]  = '{8'd143, 12'h143};
        vecs[2]  = '{8'd255, 12'h255};
        vecs[3]  = '{8'd99,  12'h099};
        vecs[4]  = '{8'd0,   12'h000};
        vecs[5]  = '{8'd78,  12'h078};
        vecs[6]  = '{8'd12,  12'h012};
        vecs[7]  = '{8'd200, 12'h200};
        vecs[8]  = '{8'd1,   12'h001};
        vecs[9]  = '{8'd100, 12'h100};
        vecs[10] = '{8'd9,   12'h009};
        vecs[11] = '{8'd10,  12'h010};

        model_reset();
        step(); step();
        check("reset_state", {bcd_hund, bcd_tens, bcd_ones, bcd_valid, busy, conv_done}, 15'd0);
        reset = 1'b0;

        // Reset asynchronously in the middle of converting 143
        S = 8'd143; mult_done = 1'b1;
        step(); step(); step(); step();
        #2 reset = 1'b1;
        #1 model_reset();
        check("async_reset_outputs", {bcd_hund, bcd_tens, bcd_ones, bcd_valid, busy, conv_done}, 15'd0);
        mult_done = 1'b0;
        step(); step();
        reset = 1'b0;
        step(); step(); step();
        check("idle_after_reset_valid", 32'(bcd_valid), 32'd0);
        check("idle_after_reset_busy", 32'(busy), 32'd0);

        // 225: busy across exactly nine samples, then a single done pulse
        begin
            int bc;
            S = 8'd225; mult_done = 1'b1;
            step();
            check("busy_after_e0", 32'(busy), 32'd1);
            bc = 1;
            for (int k = 0; k < 8; k++) begin
                step();
                if (busy) bc++;
            end
            step();
            check("busy_cycles_225", bc, 9);
            check("done_at_e9", 32'(conv_done), 32'd1);
            check("busy_low_at_e9", 32'(busy), 32'd0);
            check("digits_225", {bcd_hund, bcd_tens, bcd_ones}, 12'h225);
            check("valid_225", 32'(bcd_valid), 32'd1);
            step();
            check("done_one_cycle", 32'(conv_done), 32'd0);
        end

        // 143 held for 30 cycles: one pulse only; then 0 restarts at once
        begin
            int pulses = 0;
            S = 8'd143;
            for (int k = 0; k < 30; k++) begin
                step();
                if (conv_done) pulses++;
            end
            check("pulses_143_held", pulses, 1);
            check("digits_143", {bcd_hund, bcd_tens, bcd_ones}, 12'h143);
            S = 8'd0;
            step();
            check("restart_on_change", 32'(busy), 32'd1);
            wait_done("conv_0");
            check("digits_0", {bcd_hund, bcd_tens, bcd_ones}, 12'h000);
        end

        // Table of direct conversions
        for (int i = 0; i < 12; i++) begin
            S = vecs[i].val; mult_done = 1'b1;
            wait_done("table");
            check("table_digits", {bcd_hund, bcd_tens, bcd_ones}, vecs[i].digits);
        end

        // Abort of 78 at E4, then a full retry
        S = 8'd78;
        step(); step(); step(); step();
        mult_done = 1'b0;
        step();
        check("abort_state", {bcd_hund, bcd_tens, bcd_ones, bcd_valid, busy, conv_done}, 15'd0);
        mult_done = 1'b1;
        wait_done("retry_78");
        check("digits_78", {bcd_hund, bcd_tens, bcd_ones}, 12'h078);

        // S changes mid-conversion: snapshot kept, new value follows
        S = 8'd12;
        step(); step(); step(); step();
        S = 8'd200;
        wait_done("snap_12");
        check("digits_snap_12", {bcd_hund, bcd_tens, bcd_ones}, 12'h012);
        step();
        check("restart_200", 32'(busy), 32'd1);
        wait_done("conv_200");
        check("digits_200", {bcd_hund, bcd_tens, bcd_ones}, 12'h200);

        // Random traffic against the reference model
        for (int k = 0; k < 2000; k++) begin
            mult_done = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 7) == 0) S = 8'($urandom_range(0, 255));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
